// File: rtl/alarm_clk_key_pio_if.sv
// Avalon-MM slave bus bundle for the alarm clock key PIO.
// Signals: address (word address), chipselect, write_n (active-low write strobe),
//          writedata (32-bit), readdata (32-bit, zero-extended, combinational).
// master: drives address/chipselect/write_n/writedata and reads readdata.
// slave : the PIO side.
interface alarm_clk_key_pio_if;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/alarm_clk_key_pio.sv
// Input PIO for the alarm clock push-buttons: two-flop synchronizer and
// per-bit debounce, a write-1-to-clear edge capture register and a maskable
// level interrupt.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - Avalon-MM slave (addr 0 DATA, 1 IRQ_MASK, 2 reserved, 3 EDGE_CAPTURE)
//   in_port  - raw asynchronous key levels
//   irq      - active-high level interrupt, OR of (edge_capture & irq_mask)
module alarm_clk_key_pio #(
    parameter int unsigned     WIDTH           = 4,
    parameter int unsigned     DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL    = {WIDTH{1'b1}},
    parameter bit              CAPTURE_RISING  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alarm_clk_key_pio_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    logic [WIDTH-1:0]            r_sync1;
    logic [WIDTH-1:0]            r_sync2;
    logic [WIDTH-1:0]            r_deb;
    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]            r_mask;
    logic [WIDTH-1:0]            r_cap;

    logic [WIDTH-1:0]            w_deb_nxt;
    logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]            w_set;
    logic [WIDTH-1:0]            w_clr;
    logic                        w_wr;

    // Upper write data bits carry no register content.
    if (WIDTH < 32) begin : g_wd_hi
        logic w_unused_wd_hi;
        assign w_unused_wd_hi = ^bus.writedata[31:WIDTH];
    end

    // Per-bit debounce: counter runs only while sync2 disagrees with the
    // debounced level and restarts whenever they agree again.
    always_comb begin
        w_deb_nxt = r_deb;
        w_cnt_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] != r_deb[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_deb_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Capture qualifying debounced transitions; a set beats a same-cycle clear.
    assign w_set = CAPTURE_RISING ? (~r_deb & w_deb_nxt) : (r_deb & ~w_deb_nxt);
    assign w_wr  = bus.chipselect & ~bus.write_n;
    assign w_clr = (w_wr && (bus.address == ADDR_CAP)) ? bus.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_LEVEL;
            r_sync2 <= RESET_LEVEL;
            r_deb   <= RESET_LEVEL;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_cap   <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
            r_deb   <= w_deb_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cap   <= (r_cap & ~w_clr) | w_set;
            if (w_wr && (bus.address == ADDR_MASK)) begin
                r_mask <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    // Zero-wait-state read mux, independent of chipselect.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA: bus.readdata = 32'(r_deb);
            ADDR_MASK: bus.readdata = 32'(r_mask);
            ADDR_CAP:  bus.readdata = 32'(r_cap);
            default:   bus.readdata = '0;
        endcase
    end

    assign irq = |(r_cap & r_mask);
endmodule
